// File: rtl/alu_seq.sv
// Registered, handshaked ALU: AND/OR/ADD/SUB/NOR/NAND/SLT in one cycle, optional iterative MUL.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier (opcode 0011); otherwise 0011 is an unknown opcode.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    input  logic [2:0]       bonus_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_overflow;

    logic             w_accept;
    logic             w_is_sub;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic             w_lt;
    logic             w_eq;
    logic             w_slt_flag;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_is_sub = (ALU_control == OP_SUB);

    // Subtraction reuses the adder as src1 + ~src2 + 1 so cout means "no borrow".
    assign w_b   = w_is_sub ? ~src2 : src2;
    assign w_sum = {1'b0, src1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_is_sub};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic_bit
            assign w_and[gi] = src1[gi] & src2[gi];
            assign w_or[gi]  = src1[gi] | src2[gi];
        end
    endgenerate

    assign w_lt = $signed(src1) < $signed(src2);
    assign w_eq = (src1 == src2);

    always_comb begin
        w_slt_flag = 1'b0;
        case (bonus_control)
            3'b000:  w_slt_flag = w_lt;
            3'b001:  w_slt_flag = w_lt | w_eq;
            3'b010:  w_slt_flag = ~w_lt;
            3'b011:  w_slt_flag = ~w_eq;
            3'b110:  w_slt_flag = ~w_lt & ~w_eq;
            3'b111:  w_slt_flag = w_eq;
            default: w_slt_flag = 1'b0;
        endcase
    end

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (ALU_control)
            OP_AND:  w_res = w_and;
            OP_OR:   w_res = w_or;
            OP_NOR:  w_res = ~w_or;
            OP_NAND: w_res = ~w_and;
            OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) && (w_sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) && (w_sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt_flag};
            default: w_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam int CW = $clog2(WIDTH);
    // Step 0 runs on the accepting edge, so BUSY only has to cover steps 1..WIDTH-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   w_step_mcand;
    logic [2*WIDTH-1:0] w_step_prod;
    logic [WIDTH:0]     w_step_sum;
    logic [2*WIDTH-1:0] w_step_next;
    logic               w_mul_last;

    assign w_is_mul = (ALU_control == OP_MUL);

    // Right-shifting product register: high half accumulates, low half holds remaining multiplier bits.
    assign w_step_mcand = (r_state == S_IDLE) ? src1 : r_mcand;
    assign w_step_prod  = (r_state == S_IDLE) ? {{WIDTH{1'b0}}, src2} : r_prod;
    assign w_step_sum   = {1'b0, w_step_prod[2*WIDTH-1:WIDTH]}
                        + (w_step_prod[0] ? {1'b0, w_step_mcand} : {(WIDTH+1){1'b0}});
    assign w_step_next  = {w_step_sum, w_step_prod[WIDTH-1:1]};
    assign w_mul_last   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand <= src1;
            r_prod  <= w_step_next;
            r_cnt   <= '0;
        end else if (r_state == S_BUSY) begin
            r_prod  <= w_step_next;
            r_cnt   <= r_cnt + CW'(1);
        end
    end
`else
    assign w_is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = w_is_mul ? S_BUSY : S_DONE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_BUSY: begin
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result   <= w_res;
            r_zero     <= (w_res == '0);
            r_cout     <= w_cout;
            r_overflow <= w_ovf;
        end
`ifdef ALU_SEQ_MUL_EN
        else if ((r_state == S_BUSY) && w_mul_last) begin
            r_result   <= w_step_next[WIDTH-1:0];
            r_zero     <= (w_step_next[WIDTH-1:0] == '0);
            r_cout     <= 1'b0;
            r_overflow <= |w_step_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH 32): directed vector table plus handshake and reset sequences.
// Multiply expectations follow ALU_SEQ_MUL_EN when the bench is compiled with the same define.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ALU_control;
    logic [2:0]   bonus_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [2:0]   bc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .src1          (src1),
        .src2          (src2),
        .ALU_control   (ALU_control),
        .bonus_control (bonus_control),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .cout          (cout),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge with inputs scrambled.
    task automatic start_op(input logic [3:0] op, input logic [2:0] bc,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
        ALU_control   = op;
        bonus_control = bc;
        src1          = a;
        src2          = b;
        in_valid      = 1'b1;
        @(negedge clk);
        in_valid      = 1'b0;
        src1          = $urandom;
        src2          = $urandom;
        ALU_control   = 4'($urandom);
        bonus_control = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_consume", {63'd0, in_ready}, 64'd1);
        chk("out_valid_after_consume", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [2:0] bc,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res,
                           input logic z, input logic c, input logic v, input int lat);
        vec_t t;
        t.name = name; t.op = op; t.bc = bc; t.a = a; t.b = b;
        t.res = res; t.z = z; t.c = c; t.v = v; t.lat = lat;
        vecs.push_back(t);
    endtask

    initial begin
        int lat;
        int seen;

        add_vec("add_ovf",   4'b0010, 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1);
        add_vec("add_carry", 4'b0010, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1);
        add_vec("add_negov", 4'b0010, 3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 1);
        add_vec("sub_eq",    4'b0110, 3'b000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1);
        add_vec("sub_borrow",4'b0110, 3'b000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);
        add_vec("sub_ovf",   4'b0110, 3'b000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1);
        add_vec("and",       4'b0000, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1);
        add_vec("or",        4'b0001, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1);
        add_vec("nor",       4'b1100, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0, 1'b0, 1);
        add_vec("nand",      4'b1101, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF0FFF0F, 1'b0, 1'b0, 1'b0, 1);
        add_vec("slt_lt",    4'b0111, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        add_vec("slt_le",    4'b0111, 3'b001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        add_vec("slt_ge",    4'b0111, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        add_vec("slt_ne",    4'b0111, 3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        add_vec("slt_gt",    4'b0111, 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        add_vec("slt_eq",    4'b0111, 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        add_vec("slt_m100",  4'b0111, 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        add_vec("slt_m101",  4'b0111, 3'b101, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
        add_vec("slt_eq_t",  4'b0111, 3'b111, 32'h00000007, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        add_vec("slt_gt_t",  4'b0111, 3'b110, 32'h00000005, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
        add_vec("unknown",   4'b1111, 3'b000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1);
`ifdef ALU_SEQ_MUL_EN
        add_vec("mul_trunc", 4'b0011, 3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b1, W);
        add_vec("mul_small", 4'b0011, 3'b000, 32'd1234,     32'd5678,     32'd7006652,  1'b0, 1'b0, 1'b0, W);
`else
        add_vec("mul_absent",4'b0011, 3'b000, 32'd1234,     32'd5678,     32'h00000000, 1'b1, 1'b0, 1'b0, 1);
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; ALU_control = '0; bonus_control = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result",    {32'd0, result},    64'd0);
        chk("reset_zero",      {63'd0, zero},      64'd0);
        chk("reset_cout",      {63'd0, cout},      64'd0);
        chk("reset_overflow",  {63'd0, overflow},  64'd0);

        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].bc, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            chk({vecs[i].name, "_latency"},  64'(lat),           64'(vecs[i].lat));
            chk({vecs[i].name, "_result"},   {32'd0, result},    {32'd0, vecs[i].res});
            chk({vecs[i].name, "_zero"},     {63'd0, zero},      {63'd0, vecs[i].z});
            chk({vecs[i].name, "_cout"},     {63'd0, cout},      {63'd0, vecs[i].c});
            chk({vecs[i].name, "_overflow"}, {63'd0, overflow},  {63'd0, vecs[i].v});
            $display("txn %-10s op=%b bc=%b a=%08h b=%08h -> res=%08h z=%b c=%b v=%b lat=%0d",
                     vecs[i].name, vecs[i].op, vecs[i].bc, vecs[i].a, vecs[i].b,
                     result, zero, cout, overflow, lat);
            consume();
        end

        // Back-pressure: result held while out_ready low; issue attempts are dropped.
        start_op(4'b0010, 3'b000, 32'd3, 32'd4);
        wait_valid(lat);
        chk("stall_latency", 64'(lat), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                ALU_control = 4'b0110; src1 = 32'd100; src2 = 32'd1; in_valid = 1'b1;
            end
            @(negedge clk);
            chk("stall_result",    {32'd0, result},    64'd7);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_in_ready",  {63'd0, in_ready},  64'd0);
        end
        in_valid = 1'b0;
        consume();
        @(negedge clk);
        chk("stall_not_queued", {63'd0, out_valid}, 64'd0);
        $display("txn stall      ADD 3+4 held 10 cycles -> res=%08h", result);

        // out_ready already high before the result appears.
        out_ready = 1'b1;
        start_op(4'b0000, 3'b000, 32'hFF00FF00, 32'h0F0F0F0F);
        chk("early_ready_valid",  {63'd0, out_valid}, 64'd1);
        chk("early_ready_result", {32'd0, result},    64'h0F000F00);
        @(negedge clk);
        out_ready = 1'b0;
        chk("early_ready_consumed", {63'd0, out_valid}, 64'd0);
        chk("early_ready_in_ready", {63'd0, in_ready},  64'd1);
        $display("txn early_rdy  AND ff00ff00&0f0f0f0f -> res=%08h", result);

        // Reset wins over a pending out_ready handshake in DONE.
        start_op(4'b0010, 3'b000, 32'h7FFFFFFF, 32'h00000001);
        wait_valid(lat);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0;
        chk("rst_done_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_done_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_done_result",    {32'd0, result},    64'd0);
        chk("rst_done_overflow",  {63'd0, overflow},  64'd0);
        $display("txn rst_done   reset in DONE -> out_valid=%b res=%08h", out_valid, result);

`ifdef ALU_SEQ_MUL_EN
        // Reset part-way through a multiply: nothing may emerge afterwards.
        start_op(4'b0011, 3'b000, 32'd1234, 32'd5678);
        repeat (9) @(negedge clk);
        chk("mid_mul_busy", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_mul_in_ready",  {63'd0, in_ready},  64'd1);
        chk("mid_mul_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_mul_result",    {32'd0, result},    64'd0);
        chk("mid_mul_flags",     {61'd0, zero, cout, overflow}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_mul_no_late_result", 64'(seen), 64'd0);
        $display("txn rst_mul    reset at cycle 10 of MUL -> late valids=%0d", seen);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the lab's combinational 32-bit ALU: same opcode and bonus-compare encoding, but with a configurable datapath width, a valid/ready handshake on both sides, registered result/flags and an optional iterative shift-add multiplier. It sits between the decode stage and write-back and may hold off issue with `in_ready` while a multi-cycle operation runs.

## Interface
- `WIDTH`, 32: datapath width in bits, ≥ 4.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and opcode valid.
- `in_ready`  out  1  block can accept an operation.
- `src1`  in  WIDTH  source 1.
- `src2`  in  WIDTH  source 2.
- `ALU_control`  in  4  opcode.
- `bonus_control`  in  3  compare mode for SLT.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`.
- `cout`  out  1  carry out (ADD/SUB only, else 0).
- `overflow`  out  1  signed overflow (ADD/SUB), product truncation (MUL), else 0.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 1101 NAND, 0111 SLT, 0011 MUL (macro-gated). Any other opcode: result 0, zero 1, cout 0, overflow 0.
- ADD: {cout,result} = src1 + src2; overflow = operand signs equal and result sign differs.
- SUB: computed as src1 + ~src2 + 1; cout = carry of that sum (1 when src1 ≥ src2 unsigned); overflow = operand signs differ and result sign differs from src1.
- SLT: signed compare, result = {WIDTH-1 zeros, flag}. bonus_control: 000 lt, 001 le, 010 ge, 011 ne, 110 gt, 111 eq; 100/101 give result 0.
- MUL: unsigned, result = low WIDTH bits of product, overflow = 1 if any upper WIDTH bit nonzero. One shift-add step per cycle, WIDTH steps.
- FSM states: IDLE, BUSY (MUL only), DONE.
  - IDLE: in_ready = 1. On in_valid: single-cycle op → compute, register outputs, go DONE; MUL → latch operands, clear accumulator, counter = 0, go BUSY.
  - BUSY: in_ready = 0; counter increments each cycle; after step WIDTH-1 register result/flags, go DONE.
  - DONE: out_valid = 1, in_ready = 0; outputs stable; on out_ready go IDLE.
- Single outstanding operation; no back-to-back overlap.
- Inputs are sampled only on the accepting edge; changes afterwards have no effect.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, result 0, zero 0, cout 0, overflow 0, counter 0.
- Reset takes priority over every other event, including mid-MUL and DONE with out_ready high: operation discarded, no out_valid pulse.
- Single-cycle ops: accepted at edge k → out_valid high from edge k+1.
- MUL: accepted at edge k → out_valid high from edge k+WIDTH.
- Result consumed at edge j (out_valid & out_ready) → in_ready high from edge j+1; earliest next accept at edge j+1.
- out_ready high before out_valid has no effect; out_valid held indefinitely while out_ready low, with result and flags unchanged.
- in_valid while in_ready is 0 is ignored (not queued).

## Configuration
- `ALU_SEQ_MUL_EN` defined: opcode 0011 performs the iterative multiply and BUSY state/counter/accumulator are present.
- Not defined: no multiplier hardware, BUSY never entered; 0011 treated as unknown opcode (result 0, zero 1, latency 1).

## Test plan
- Reset, then ADD 0x7FFFFFFF + 0x00000001 → one cycle later out_valid, result 0x80000000, overflow 1, cout 0, zero 0.
- SUB 5 − 5 → result 0, zero 1, cout 1, overflow 0; SUB 0 − 1 → 0xFFFFFFFF, cout 0.
- SLT src1 = 0xFFFFFFFF (−1), src2 = 1 across bonus 000/001/010/011/110/111 → results 1,1,0,1,0,0; bonus 100 → 0.
- MUL (macro on) 0x00010000 × 0x00010000 → out_valid exactly 32 cycles after accept, result 0, overflow 1, zero 1; 1234 × 5678 → 7006652, overflow 0.
- out_ready held low 10 cycles after out_valid → result stable, in_ready 0, new in_valid ignored; release → in_ready 1 next cycle.
- rst asserted at cycle 10 of a MUL → next cycle in_ready 1, out_valid 0, all outputs 0; no late result appears.
